snes_joy_serializer: RTL and testbench

- Generalised SNES controller-port emulator. Replaces the single-port, inline 16-bit joypad shift register at the top level.
- Converts parallel button state from any source (ULX3S buttons, ESP32 SPI, USB bridge) into the serial JOY_DI protocol expected by the main SNES core.
- Supports N ports, configurable pad width and a configurable fill bit after the last bit.
- Has input synchronisers and optional turbo/autofire.

---
 rtl/snes_joy_serializer.sv | 141 ++++++++++++++
 tb/tb_snes_joy_serializer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/snes_joy_serializer.sv
// snes_joy_serializer
// SNES controller-port emulator: latches parallel button state on the core's
// strobe and shifts it out, active-low, one bit per rising edge of each
// port's joy_clk. Strobe and serial clocks come from the core and are
// resynchronised into clk before edge detection.
//
// Optional build macro: SNES_JOY_TURBO_EN
//   defined   -> buttons selected by turbo_mask alternate between pressed and
//                released every TURBO_PERIOD strobes
//   undefined -> turbo_mask is ignored and buttons pass straight through
module snes_joy_serializer #(
    parameter int NUM_PORTS    = 2,
    parameter int PAD_BITS     = 16,
    parameter bit FILL_BIT     = 1'b0,
    parameter int SYNC_STAGES  = 2,
    parameter int TURBO_PERIOD = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS*PAD_BITS-1:0]   buttons,
    input  logic [NUM_PORTS*PAD_BITS-1:0]   turbo_mask,
    input  logic                            joy_strb,
    input  logic [NUM_PORTS-1:0]            joy_clk,
    output logic [NUM_PORTS-1:0]            joy_di,
    output logic [NUM_PORTS-1:0]            joy_done
);

    localparam int CW = $clog2(PAD_BITS + 1);

    // ------------------------------------------------------------------
    // Strobe synchroniser and rising-edge detector (shared by all ports)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_strb_sync;
    logic                   r_strb_dly;
    logic                   w_strb_s;
    logic                   w_strb_rise;

    // Resynchronise the strobe; idle value is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_strb_sync <= '0;
            r_strb_dly  <= 1'b0;
        end else begin
            r_strb_sync <= {r_strb_sync[SYNC_STAGES-2:0], joy_strb};
            r_strb_dly  <= r_strb_sync[SYNC_STAGES-1];
        end
    end

    assign w_strb_s    = r_strb_sync[SYNC_STAGES-1];
    assign w_strb_rise = w_strb_s & ~r_strb_dly;

    // ------------------------------------------------------------------
    // Effective button state (turbo masking)
    // ------------------------------------------------------------------
    logic [NUM_PORTS*PAD_BITS-1:0] w_eff;
    logic                          w_turbo_off;

`ifdef SNES_JOY_TURBO_EN
    localparam int TW = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;

    logic [TW-1:0] r_turbo_cnt;
    logic          r_turbo_phase;

    // Count strobes; every TURBO_PERIOD strobes flip the autofire phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_turbo_cnt   <= '0;
            r_turbo_phase <= 1'b0;
        end else if (w_strb_rise) begin
            if (r_turbo_cnt == TW'(TURBO_PERIOD - 1)) begin
                r_turbo_cnt   <= '0;
                r_turbo_phase <= ~r_turbo_phase;
            end else begin
                r_turbo_cnt <= r_turbo_cnt + 1'b1;
            end
        end
    end

    assign w_turbo_off = r_turbo_phase;
    assign w_eff       = buttons & ~(turbo_mask & {(NUM_PORTS*PAD_BITS){w_turbo_off}});
`else
    // Without autofire the mask and period have no effect
    logic w_unused_turbo;
    assign w_unused_turbo = (^turbo_mask) ^ (TURBO_PERIOD == 0);
    assign w_turbo_off    = 1'b0;
    assign w_eff          = buttons;
`endif

    // ------------------------------------------------------------------
    // Per-port serial clock synchroniser, shift register and bit counter
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        logic [SYNC_STAGES-1:0] r_clk_sync;
        logic                   r_clk_dly;
        logic [PAD_BITS-1:0]    r_shift;
        logic [CW-1:0]          r_cnt;
        logic                   r_done;
        logic [PAD_BITS-1:0]    w_eff_p;
        logic                   w_clk_rise;
        logic [CW:0]            w_cnt_inc;

        assign w_eff_p    = w_eff[gi*PAD_BITS +: PAD_BITS];
        assign w_clk_rise = r_clk_sync[SYNC_STAGES-1] & ~r_clk_dly;
        assign w_cnt_inc  = {1'b0, r_cnt} + 1'b1;

        // Resynchronise joy_clk; reset to the idle-high level so that
        // releasing reset never looks like a rising edge
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_clk_sync <= '1;
                r_clk_dly  <= 1'b1;
            end else begin
                r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], joy_clk[gi]};
                r_clk_dly  <= r_clk_sync[SYNC_STAGES-1];
            end
        end

        // Latch while the strobe is high (strobe wins), otherwise shift on edges
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_shift <= '1;
                r_cnt   <= '0;
                r_done  <= 1'b0;
            end else if (w_strb_s) begin
                r_shift <= ~w_eff_p;
                r_cnt   <= '0;
                r_done  <= 1'b0;
            end else if (w_clk_rise) begin
                r_shift <= {FILL_BIT, r_shift[PAD_BITS-1:1]};
                if (w_cnt_inc <= (CW+1)'(PAD_BITS)) begin
                    r_cnt <= w_cnt_inc[CW-1:0];
                end
                r_done  <= (w_cnt_inc >= (CW+1)'(PAD_BITS));
            end
        end

        assign joy_di[gi]   = r_shift[0];
        assign joy_done[gi] = r_done;
    end

endmodule

// File: tb/tb_snes_joy_serializer.sv
// Directed testbench for snes_joy_serializer (2 ports, 16-bit pads).
// Turbo expectations follow the SNES_JOY_TURBO_EN build macro.
module tb_snes_joy_serializer;

    localparam int NP = 2;
    localparam int PB = 16;

    logic              clk;
    logic              reset;
    logic [NP*PB-1:0]  buttons;
    logic [NP*PB-1:0]  turbo_mask;
    logic              joy_strb;
    logic [NP-1:0]     joy_clk;
    logic [NP-1:0]     joy_di;
    logic [NP-1:0]     joy_done;

    int n_vec;
    int n_err;

    snes_joy_serializer #(
        .NUM_PORTS    (NP),
        .PAD_BITS     (PB),
        .FILL_BIT     (1'b0),
        .SYNC_STAGES  (2),
        .TURBO_PERIOD (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .buttons    (buttons),
        .turbo_mask (turbo_mask),
        .joy_strb   (joy_strb),
        .joy_clk    (joy_clk),
        .joy_di     (joy_di),
        .joy_done   (joy_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-clock strobe pulse at the pin, then let it settle
    task automatic strobe_pulse();
        joy_strb = 1'b1;
        cycles(1);
        joy_strb = 1'b0;
        cycles(5);
    endtask

    // One low-then-high pulse on the selected joy_clk lines
    task automatic clk_pulse(input logic [NP-1:0] m);
        joy_clk = joy_clk & ~m;
        cycles(4);
        joy_clk = joy_clk | m;
        cycles(4);
    endtask

    logic [PB-1:0] exp0, exp1;
    logic [5:0]    turbo_exp;

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        buttons    = '0;
        turbo_mask = '0;
        joy_strb   = 1'b0;
        joy_clk    = '1;
        cycles(3);
        chk("reset_di",   32'(joy_di),   32'h3);
        chk("reset_done", 32'(joy_done), 32'h0);

        // Idle after reset: nothing moves with joy_clk held high
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            chk("idle", 32'({joy_di, joy_done}), 32'hC);
        end

        // Port 0 single button, 17 edges on port 0 only
        buttons = {16'h0000, 16'h0001};
        strobe_pulse();
        exp0 = ~16'h0001;
        chk("p0_bit0", 32'(joy_di), 32'b10);
        for (int k = 1; k <= 17; k++) begin
            clk_pulse(2'b01);
            exp0 = {1'b0, exp0[PB-1:1]};
            chk("p0_shift_di",   32'(joy_di[0]),   32'(exp0[0]));
            chk("p0_shift_done", 32'(joy_done[0]), 32'(k >= PB));
            chk("p1_idle",       32'({joy_di[1], joy_done[1]}), 32'b10);
        end

        // Strobe held high: joy_clk ignored, output follows buttons live
        buttons  = {16'h0000, 16'h0003};
        joy_strb = 1'b1;
        cycles(5);
        chk("hold_bit0", 32'(joy_di[0]), 32'h0);
        for (int k = 0; k < 5; k++) begin
            clk_pulse(2'b01);
            chk("hold_noshift", 32'({joy_di[0], joy_done[0]}), 32'h0);
        end
        buttons = {16'h0000, 16'h0002};
        cycles(5);
        chk("hold_live", 32'(joy_di[0]), 32'h1);
        joy_strb = 1'b0;
        cycles(5);
        buttons = '1;
        exp0 = ~16'h0002;
        for (int k = 1; k <= 3; k++) begin
            clk_pulse(2'b01);
            exp0 = {1'b0, exp0[PB-1:1]};
            chk("hold_shift", 32'(joy_di[0]), 32'(exp0[0]));
        end

        // Two ports clocked together, no cross-talk
        buttons = {16'h0F00, 16'h00F0};
        strobe_pulse();
        exp0 = ~16'h00F0;
        exp1 = ~16'h0F00;
        chk("dual_bit0", 32'(joy_di), 32'({exp1[0], exp0[0]}));
        for (int k = 1; k <= 17; k++) begin
            clk_pulse(2'b11);
            exp0 = {1'b0, exp0[PB-1:1]};
            exp1 = {1'b0, exp1[PB-1:1]};
            chk("dual_di",   32'(joy_di),   32'({exp1[0], exp0[0]}));
            chk("dual_done", 32'(joy_done), (k >= PB) ? 32'h3 : 32'h0);
        end

        // Reset in the middle of a read, then a clean read
        buttons = {16'h0000, 16'hA5C3};
        strobe_pulse();
        exp0 = ~16'hA5C3;
        for (int k = 1; k <= 7; k++) begin
            clk_pulse(2'b01);
            exp0 = {1'b0, exp0[PB-1:1]};
        end
        chk("mid_di",   32'(joy_di[0]),   32'(exp0[0]));
        chk("mid_done", 32'(joy_done[0]), 32'h0);
        reset = 1'b1;
        #1;
        chk("async_di",   32'(joy_di),   32'h3);
        chk("async_done", 32'(joy_done), 32'h0);
        cycles(2);
        reset = 1'b0;
        cycles(3);
        chk("post_rst_di", 32'(joy_di), 32'h3);
        strobe_pulse();
        exp0 = ~16'hA5C3;
        chk("reread_bit0", 32'(joy_di[0]), 32'(exp0[0]));
        for (int k = 1; k <= 16; k++) begin
            clk_pulse(2'b01);
            exp0 = {1'b0, exp0[PB-1:1]};
            chk("reread_di",   32'(joy_di[0]),   32'(exp0[0]));
            chk("reread_done", 32'(joy_done[0]), 32'(k >= PB));
        end

        // Turbo: fresh counter, bit 0 across six strobes
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(3);
        buttons    = {16'h0000, 16'h0001};
        turbo_mask = {16'h0000, 16'h0001};
`ifdef SNES_JOY_TURBO_EN
        turbo_exp = 6'b001100;
`else
        turbo_exp = 6'b000000;
`endif
        for (int s = 0; s < 6; s++) begin
            strobe_pulse();
            chk("turbo_bit0", 32'(joy_di[0]), 32'(turbo_exp[5-s]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
